// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/wait sequencing for the 5-stage RV32I pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int CHECK_WB    = 1,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rs1_addr_id,
    input  logic [4:0]       i_rs2_addr_id,
    input  logic             i_rs1_used_id,
    input  logic             i_rs2_used_id,
    input  logic             i_inst_vld_id,
    input  logic [4:0]       i_rd_addr_ex,
    input  logic [4:0]       i_rd_addr_mem,
    input  logic [4:0]       i_rd_addr_wb,
    input  logic             i_rd_wren_ex,
    input  logic             i_rd_wren_mem,
    input  logic             i_rd_wren_wb,
    input  logic             i_pc_sel_ex,
    input  logic             i_mem_busy,
    output logic             o_enable_pc,
    output logic             o_enable_if,
    output logic             o_enable_id,
    output logic             o_enable_ex,
    output logic             o_enable_mem,
    output logic             o_reset_if,
    output logic             o_reset_id,
    output logic             o_reset_ex,
    output logic             o_reset_mem,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
    output logic [CNT_W-1:0] o_wait_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    localparam logic [1:0]       c_FLUSH_LOAD = 2'(FLUSH_EXTRA);
    localparam logic             c_CHECK_WB   = (CHECK_WB != 0);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_flush_left;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_wait_cnt;

    logic   w_src1_hz;
    logic   w_src2_hz;
    logic   w_hazard;
    state_t w_state;

    // A source conflicts with any in-flight writer that has not yet reached the regfile
    always_comb begin
        w_src1_hz = i_rs1_used_id && (i_rs1_addr_id != 5'd0) &&
                    ((i_rd_wren_ex  && (i_rs1_addr_id == i_rd_addr_ex))  ||
                     (i_rd_wren_mem && (i_rs1_addr_id == i_rd_addr_mem)) ||
                     (c_CHECK_WB && i_rd_wren_wb && (i_rs1_addr_id == i_rd_addr_wb)));
        w_src2_hz = i_rs2_used_id && (i_rs2_addr_id != 5'd0) &&
                    ((i_rd_wren_ex  && (i_rs2_addr_id == i_rd_addr_ex))  ||
                     (i_rd_wren_mem && (i_rs2_addr_id == i_rd_addr_mem)) ||
                     (c_CHECK_WB && i_rd_wren_wb && (i_rs2_addr_id == i_rd_addr_wb)));
        w_hazard  = i_inst_vld_id && (w_src1_hz || w_src2_hz);
    end

    always_comb begin
        w_state = ST_RUN;
        if (i_mem_busy) begin
            w_state = ST_WAIT;
        end else if (i_pc_sel_ex || (r_flush_left != 2'd0)) begin
            w_state = ST_FLUSH;
        end else if (w_hazard) begin
            w_state = ST_STALL;
        end
    end

    always_comb begin
        o_enable_pc  = 1'b1;
        o_enable_if  = 1'b1;
        o_enable_id  = 1'b1;
        o_enable_ex  = 1'b1;
        o_enable_mem = 1'b1;
        o_reset_if   = 1'b1;
        o_reset_id   = 1'b1;
        o_reset_ex   = 1'b1;
        o_reset_mem  = 1'b1;
        o_state      = w_state;
        if (!i_reset) begin
            o_reset_if  = 1'b0;
            o_reset_id  = 1'b0;
            o_reset_ex  = 1'b0;
            o_reset_mem = 1'b0;
            o_state     = ST_RUN;
        end else begin
            case (w_state)
                ST_WAIT: begin
                    o_enable_pc  = 1'b0;
                    o_enable_if  = 1'b0;
                    o_enable_id  = 1'b0;
                    o_enable_ex  = 1'b0;
                    o_enable_mem = 1'b0;
                end
                ST_FLUSH: begin
                    // Fresh redirect kills both younger stages; trailing cycles only IF/ID
                    o_reset_if = 1'b0;
                    o_reset_id = !i_pc_sel_ex;
                end
                ST_STALL: begin
                    o_enable_pc = 1'b0;
                    o_enable_if = 1'b0;
                    o_reset_id  = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_flush_left <= 2'd0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_wait_cnt   <= '0;
        end else begin
            case (w_state)
                ST_WAIT: begin
                    if (r_wait_cnt != '1) begin
                        r_wait_cnt <= r_wait_cnt + c_CNT_ONE;
                    end
                end
                ST_FLUSH: begin
                    if (i_pc_sel_ex) begin
                        r_flush_left <= c_FLUSH_LOAD;
                        if (r_flush_cnt != '1) begin
                            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
                        end
                    end else begin
                        r_flush_left <= r_flush_left - 2'd1;
                    end
                end
                ST_STALL: begin
                    if (r_stall_cnt != '1) begin
                        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;
    assign o_wait_cnt  = r_wait_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed bench for hazard_ctrl with an in-bench reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam int FE_A = 1;
    localparam int W_A  = 4;
    localparam int FE_B = 0;
    localparam int W_B  = 32;

    logic       clk = 1'b0;
    logic       rst_n, busy, pc_sel, vld, u1, u2, wr_ex, wr_mem, wr_wb;
    logic [4:0] rs1, rs2, rd_ex, rd_mem, rd_wb;

    logic           a_en_pc, a_en_if, a_en_id, a_en_ex, a_en_mem;
    logic           a_rs_if, a_rs_id, a_rs_ex, a_rs_mem;
    logic [1:0]     a_state;
    logic [W_A-1:0] a_stall, a_flush, a_wait;
    logic           b_en_pc, b_en_if, b_en_id, b_en_ex, b_en_mem;
    logic           b_rs_if, b_rs_id, b_rs_ex, b_rs_mem;
    logic [1:0]     b_state;
    logic [W_B-1:0] b_stall, b_flush, b_wait;

    int  n_pass = 0;
    int  n_total = 0;
    bit  started = 0;
    int  fa = 0, sa = 0, fla = 0, wa = 0;
    int  fb = 0, sb = 0, flb = 0, wb = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_EXTRA(FE_A), .CHECK_WB(1), .CNT_W(W_A)) u_dut_a (
        .i_clk(clk), .i_reset(rst_n),
        .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
        .i_rs1_used_id(u1), .i_rs2_used_id(u2), .i_inst_vld_id(vld),
        .i_rd_addr_ex(rd_ex), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
        .i_rd_wren_ex(wr_ex), .i_rd_wren_mem(wr_mem), .i_rd_wren_wb(wr_wb),
        .i_pc_sel_ex(pc_sel), .i_mem_busy(busy),
        .o_enable_pc(a_en_pc), .o_enable_if(a_en_if), .o_enable_id(a_en_id),
        .o_enable_ex(a_en_ex), .o_enable_mem(a_en_mem),
        .o_reset_if(a_rs_if), .o_reset_id(a_rs_id), .o_reset_ex(a_rs_ex),
        .o_reset_mem(a_rs_mem), .o_state(a_state),
        .o_stall_cnt(a_stall), .o_flush_cnt(a_flush), .o_wait_cnt(a_wait)
    );

    hazard_ctrl #(.FLUSH_EXTRA(FE_B), .CHECK_WB(0), .CNT_W(W_B)) u_dut_b (
        .i_clk(clk), .i_reset(rst_n),
        .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
        .i_rs1_used_id(u1), .i_rs2_used_id(u2), .i_inst_vld_id(vld),
        .i_rd_addr_ex(rd_ex), .i_rd_addr_mem(rd_mem), .i_rd_addr_wb(rd_wb),
        .i_rd_wren_ex(wr_ex), .i_rd_wren_mem(wr_mem), .i_rd_wren_wb(wr_wb),
        .i_pc_sel_ex(pc_sel), .i_mem_busy(busy),
        .o_enable_pc(b_en_pc), .o_enable_if(b_en_if), .o_enable_id(b_en_id),
        .o_enable_ex(b_en_ex), .o_enable_mem(b_en_mem),
        .o_reset_if(b_rs_if), .o_reset_id(b_rs_id), .o_reset_ex(b_rs_ex),
        .o_reset_mem(b_rs_mem), .o_state(b_state),
        .o_stall_cnt(b_stall), .o_flush_cnt(b_flush), .o_wait_cnt(b_wait)
    );

    wire [10:0] a_ctl = {a_en_pc, a_en_if, a_en_id, a_en_ex, a_en_mem,
                         a_rs_if, a_rs_id, a_rs_ex, a_rs_mem, a_state};
    wire [10:0] b_ctl = {b_en_pc, b_en_if, b_en_id, b_en_ex, b_en_mem,
                         b_rs_if, b_rs_id, b_rs_ex, b_rs_mem, b_state};

    localparam logic [10:0] RUN_VEC = 11'b11111_1111_00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Does the ID instruction read a register some older in-flight instruction will write?
    function automatic bit reads_pending(input bit cwb, input logic [4:0] rs, input logic used);
        bit hit = 0;
        if (used && rs != 5'd0) begin
            if (wr_ex && rd_ex == rs) hit = 1;
            if (wr_mem && rd_mem == rs) hit = 1;
            if (cwb && wr_wb && rd_wb == rs) hit = 1;
        end
        return hit;
    endfunction

    function automatic bit hz(input bit cwb);
        return vld && (reads_pending(cwb, rs1, u1) || reads_pending(cwb, rs2, u2));
    endfunction

    // Expected {enables pc,if,id,ex,mem; clears if,id,ex,mem; state}
    function automatic logic [10:0] exp_ctl(input bit cwb, input int flush_left);
        if (!rst_n) return {5'b11111, 4'b0000, 2'd0};
        if (busy)   return {5'b00000, 4'b1111, 2'd3};
        if (pc_sel) return {5'b11111, 4'b0011, 2'd2};
        if (flush_left > 0) return {5'b11111, 4'b0111, 2'd2};
        if (hz(cwb)) return {5'b00111, 4'b1011, 2'd1};
        return RUN_VEC;
    endfunction

    function automatic int sat_inc(input int v, input int w);
        longint lim = (64'd1 << w) - 1;
        return (longint'(v) < lim) ? v + 1 : v;
    endfunction

    task automatic model_step(input bit cwb, input int fe, input int w,
                              inout int f, inout int st, inout int fl, inout int wt);
        if (!rst_n) begin
            f = 0; st = 0; fl = 0; wt = 0;
        end else if (busy) begin
            wt = sat_inc(wt, w);
        end else if (pc_sel) begin
            f = fe;
            fl = sat_inc(fl, w);
        end else if (f > 0) begin
            f = f - 1;
        end else if (hz(cwb)) begin
            st = sat_inc(st, w);
        end
    endtask

    always @(posedge clk) begin
        model_step(1'b1, FE_A, W_A, fa, sa, fla, wa);
        model_step(1'b0, FE_B, W_B, fb, sb, flb, wb);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("ctl_a", 32'(a_ctl), 32'(exp_ctl(1'b1, fa)));
            chk("ctl_b", 32'(b_ctl), 32'(exp_ctl(1'b0, fb)));
            chk("stall_a", 32'(a_stall), sa);
            chk("flush_a", 32'(a_flush), fla);
            chk("wait_a", 32'(a_wait), wa);
            chk("stall_b", b_stall, sb);
            chk("flush_b", b_flush, flb);
            chk("wait_b", b_wait, wb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stage();
        vld = 0; u1 = 0; u2 = 0; rs1 = 0; rs2 = 0;
        rd_ex = 0; rd_mem = 0; rd_wb = 0; wr_ex = 0; wr_mem = 0; wr_wb = 0;
        busy = 0; pc_sel = 0;
    endtask

    task automatic pulse_reset();
        clear_stage();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        clear_stage();
        rst_n = 0; busy = 1; pc_sel = 1;
        tick();
        started = 1;
        tick(); tick();
        #1;
        chk("lit_rst_ctl", 32'(a_ctl), 32'({5'b11111, 4'b0000, 2'd0}));
        chk("lit_rst_cnt", 32'({a_stall, a_flush, a_wait}), 0);
        rst_n = 1; busy = 0; pc_sel = 0;
        #1 chk("lit_run", 32'(a_ctl), 32'(RUN_VEC));
        tick();

        // ADDI x5 immediately followed by ADD x6,x5,x5
        vld = 1; rs1 = 5; rs2 = 5; u1 = 1; u2 = 1;
        rd_ex = 5; wr_ex = 1;
        #1 chk("lit_lu_if", 32'({a_en_if, a_rs_id, b_en_if, b_rs_id}), 0);
        tick();
        rd_ex = 0; wr_ex = 0; rd_mem = 5; wr_mem = 1;
        tick();
        rd_mem = 0; wr_mem = 0; rd_wb = 5; wr_wb = 1;
        #1 chk("lit_lu_wb", 32'({a_en_if, b_en_if}), 32'(2'b01));
        tick();
        rd_wb = 0; wr_wb = 0;
        #1 chk("lit_lu_free", 32'(a_en_if), 1);
        tick();
        chk("lit_lu_cnt_a", 32'(a_stall), 3);
        chk("lit_lu_cnt_b", b_stall, 2);
        pulse_reset();

        // x0 destination and unused rs2 never stall
        vld = 1; rs1 = 0; u1 = 1; rs2 = 7; u2 = 0;
        rd_ex = 0; wr_ex = 1;
        tick();
        rd_ex = 7;
        tick();
        rd_ex = 0; wr_ex = 0; rd_mem = 7; wr_mem = 1;
        tick();
        rd_mem = 0; wr_mem = 0;
        chk("lit_x0_cnt", 32'(a_stall) + b_stall, 0);

        // Redirect with a concurrent hazard
        rs1 = 5; u1 = 1; rd_ex = 5; wr_ex = 1; pc_sel = 1;
        #1 chk("lit_rd_c0", 32'(a_ctl), 32'({5'b11111, 4'b0011, 2'd2}));
        tick();
        pc_sel = 0; rd_ex = 0; wr_ex = 0;
        #1 chk("lit_rd_c1", 32'(a_ctl), 32'({5'b11111, 4'b0111, 2'd2}));
        chk("lit_rd_c1_b", 32'(b_ctl), 32'(RUN_VEC));
        tick();
        #1 chk("lit_rd_c2", 32'(a_ctl), 32'(RUN_VEC));
        tick();
        chk("lit_rd_cnt", 32'({a_flush, a_stall}), 32'({4'd1, 4'd0}));
        pulse_reset();

        // Memory wait holding a pending redirect
        busy = 1; pc_sel = 1;
        #1 chk("lit_wait_ctl", 32'(a_ctl), 32'({5'b00000, 4'b1111, 2'd3}));
        repeat (4) tick();
        chk("lit_wait_cnt", 32'({a_wait, a_flush}), 32'({4'd4, 4'd0}));
        busy = 0;
        #1 chk("lit_wait_drop", 32'({a_rs_if, a_rs_id}), 0);
        tick();
        pc_sel = 0;
        tick(); tick();
        chk("lit_wait_flush", 32'({a_flush, a_wait}), 32'({4'd1, 4'd4}));

        // Reset mid-flush leaves no trailing flush cycle
        pc_sel = 1;
        tick();
        pc_sel = 0; rst_n = 0;
        tick();
        rst_n = 1;
        #1 chk("lit_mid_rst", 32'({a_rs_if, a_flush}), 32'({1'b1, 4'd0}));
        tick();

        // Redirect re-triggered while already flushing
        pc_sel = 1;
        tick(); tick();
        pc_sel = 0;
        tick(); tick();
        chk("lit_retrig", 32'(a_flush), 2);
        pulse_reset();

        // Saturation on the narrow counter
        vld = 1; rs1 = 5; u1 = 1; rd_ex = 5; wr_ex = 1;
        repeat (20) tick();
        chk("lit_sat_a", 32'(a_stall), 15);
        chk("lit_sat_b", b_stall, 20);
        tick();
        chk("lit_sat_hold", 32'(a_stall), 15);

        clear_stage();
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core: drives per-stage enable (hold) and active-low clear (flush) signals for the IF/ID, ID/EX, EX/MEM and MEM/WB registers plus a PC enable, replacing the constant-1 ties in the top level. Resolves RAW data hazards by stall-and-bubble (no forwarding in the core), branch/jump redirects by flush, and multi-cycle memory waits by freezing the pipe. Keeps saturating performance counters for stalls, flushes and wait cycles.

## Interface
- FLUSH_EXTRA, 1, extra cycles (0–3) IF/ID stays cleared after a redirect, covering the registered target path
- CHECK_WB, 1, 1 = WB-stage rd counts as a hazard (regfile has no write-through); 0 = ignored
- CNT_W, 32, performance counter width
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_rs1_addr_id, i_rs2_addr_id  in  5  source registers of instruction in ID
- i_rs1_used_id, i_rs2_used_id  in  1  source actually read by the ID instruction
- i_inst_vld_id  in  1  ID holds a valid instruction
- i_rd_addr_ex / i_rd_addr_mem / i_rd_addr_wb  in  5  destination in EX / MEM / WB
- i_rd_wren_ex / i_rd_wren_mem / i_rd_wren_wb  in  1  destination write enable per stage
- i_pc_sel_ex  in  1  taken branch/jump resolved in EX
- i_mem_busy  in  1  LSU not ready; MEM access must be held
- o_enable_pc  out  1  PC update enable
- o_enable_if, o_enable_id, o_enable_ex, o_enable_mem  out  1  register load enable (0 = hold)
- o_reset_if, o_reset_id, o_reset_ex, o_reset_mem  out  1  active-low register clear (0 = bubble)
- o_state  out  2  RUN=0, STALL=1, FLUSH=2, WAIT=3
- o_stall_cnt, o_flush_cnt, o_wait_cnt  out  CNT_W  saturating event counters

## Operation
- Hazard: hz = i_inst_vld_id & (src1 | src2); srcN = used & addr≠0 & ((wren_ex & addr==rd_ex) | (wren_mem & addr==rd_mem) | (CHECK_WB & wren_wb & addr==rd_wb)).
- Priority per cycle: reset > i_mem_busy > redirect (i_pc_sel_ex or flush counter ≠0) > hz > normal.
- Normal (RUN): all enables 1, all clears 1.
- Mem wait: all enables 0 incl. PC, all clears 1; state WAIT; o_wait_cnt +1. Pending redirect/hazard is frozen in the registers and is acted on the first cycle busy drops.
- Redirect on i_pc_sel_ex: o_reset_if=0, o_reset_id=0, enables 1, PC loads target; flush counter ← FLUSH_EXTRA; state FLUSH; o_flush_cnt +1 (once per redirect).
- FLUSH with counter>0: o_reset_if=0 only, enables 1; counter −1; back to RUN (or STALL/FLUSH per priority) when counter reaches 0. A new i_pc_sel_ex in FLUSH reloads counter and counts again.
- Hazard: o_enable_pc=0, o_enable_if=0 (ID instruction held), o_reset_id=0 (bubble into EX), EX/MEM stages run; state STALL; o_stall_cnt +1 per cycle. Redirect in same cycle wins; hazard ignored.
- Counters saturate at all-ones; no wrap.
- State register is bookkeeping; control outputs are combinational from state, flush counter and inputs.

## Timing
- Reset (i_reset=0 at posedge): state RUN, flush counter 0, counters 0. While i_reset=0: all o_reset_*=0, all enables 1, o_enable_pc=1, o_state=0.
- Reset mid-WAIT/FLUSH/STALL: abandoned next edge; no residue in counter.
- Zero-latency control: outputs respond in the same cycle as the causing input.
- Load-use with CHECK_WB=1: dependent instruction stalls 3 cycles behind an immediately preceding producer, 2 behind a one-gap producer, 1 behind a two-gap producer.
- Redirect penalty: 2 + FLUSH_EXTRA bubbles.
- Counter increments visible the cycle after the event edge.

## Test plan
- Reset: hold i_reset=0 3 cycles with i_mem_busy=1, i_pc_sel_ex=1 -> all clears 0, enables 1, counters 0, o_state=0; release -> RUN, all outputs 1.
- Back-to-back RAW: ADDI x5 then ADD x6,x5,x5 (CHECK_WB=1) -> o_enable_if=0, o_reset_id=0 for exactly 3 cycles, o_stall_cnt=3; with CHECK_WB=0 -> 2 cycles.
- x0 and unused source: rd=0 wren=1 matching rs1=0, or rs2 match with rs2_used=0 -> no stall, o_stall_cnt=0.
- Redirect, FLUSH_EXTRA=1: i_pc_sel_ex pulse 1 cycle -> cycle0 o_reset_if=o_reset_id=0, cycle1 o_reset_if=0 only, cycle2 RUN; o_flush_cnt=1; concurrent hazard produces no stall count.
- Busy during redirect: i_mem_busy=1 for 4 cycles while i_pc_sel_ex=1 -> all enables 0, clears 1, o_wait_cnt=4; flush occurs on cycle busy drops.
- Saturation with CNT_W=4: 20 stall cycles -> o_stall_cnt=15 and holds.
